// File: rtl/lsu_pkg.sv
// Shared constants, FSM state encoding and size/mode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MODE_WORD = 3'b000;
    localparam logic [2:0] MODE_HALF = 3'b001;
    localparam logic [2:0] MODE_BYTE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_FAULT
    } state_e;

    // Access width in bytes; funct3[1:0] carries the width for both loads and stores.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) f3_legal = (funct3 inside {F3_B, F3_H, F3_W});
        else    f3_legal = (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic [2:0] mode_of(input logic [2:0] size);
        case (size)
            3'd1:    mode_of = MODE_BYTE;
            3'd2:    mode_of = MODE_HALF;
            default: mode_of = MODE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-data extension: sign-extends LB/LH, zero-masks LBU/LHU, passes LW through.
// Purely combinational, shared by aligned and byte-split load paths.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            F3_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   data_o = {24'b0, raw_i[7:0]};
            F3_HU:   data_o = {16'b0, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one request per handshake, ISSUE/CAPTURE per dmem transfer, one-cycle response strobe.
// Optional MISALIGN_SPLIT_EN turns misaligned half/word accesses into sequential big-endian byte accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
`ifdef MISALIGN_SPLIT_EN
    logic        split_q, split_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_idx;
    logic [1:0]  byte_sel;
`endif

    logic [2:0]  acc_size;
    logic [2:0]  cur_size;
    logic [32:0] acc_end;
    logic        acc_mis;
    logic        acc_fault;
    logic [31:0] ext_data;

    assign acc_size = size_of(req_funct3);
    // One extra bit so addresses near 2^32 cannot wrap past the range check.
    assign acc_end  = {1'b0, req_addr} + {30'b0, acc_size};
    assign acc_mis  = ((acc_size == 3'd2) && req_addr[0]) ||
                      ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign cur_size = size_of(f3_q);

`ifdef MISALIGN_SPLIT_EN
    assign acc_fault = !f3_legal(req_we, req_funct3) || (acc_end > 33'(MEM_BYTES));
    assign last_idx  = 2'(cur_size - 3'd1);
    // Byte k of a split store is the k-th most significant byte of the right-aligned data.
    assign byte_sel  = last_idx - cnt_q;
`else
    assign acc_fault = !f3_legal(req_we, req_funct3) || (acc_end > 33'(MEM_BYTES)) || acc_mis;
`endif

    lsu_extend u_extend (
        .funct3_i (f3_q),
        .raw_i    (data_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
`ifdef MISALIGN_SPLIT_EN
        split_d    = split_q;
        cnt_d      = cnt_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = '0;
        mem_a      = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        mem_mode   = MODE_WORD;

        case (state_q)
            // RESP and FAULT also accept, so a held req_valid is taken at the edge ending the response.
            S_IDLE, S_RESP, S_FAULT: begin
                req_ready  = 1'b1;
                resp_valid = (state_q != S_IDLE);
                resp_fault = (state_q == S_FAULT);
                if ((state_q == S_RESP) && !we_q) resp_rdata = ext_data;
                state_d = S_IDLE;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    data_d  = '0;
                    state_d = acc_fault ? S_FAULT : S_ISSUE;
`ifdef MISALIGN_SPLIT_EN
                    split_d = acc_mis;
                    cnt_d   = 2'd0;
`endif
                end
            end

            S_ISSUE, S_CAPTURE: begin
                mem_we   = (state_q == S_ISSUE) && we_q;
                mem_a    = addr_q;
                mem_mode = mode_of(cur_size);
                case (cur_size)
                    3'd1:    mem_wd = {24'b0, wdata_q[7:0]};
                    3'd2:    mem_wd = {16'b0, wdata_q[15:0]};
                    default: mem_wd = wdata_q;
                endcase
`ifdef MISALIGN_SPLIT_EN
                if (split_q) begin
                    mem_a    = addr_q + {30'b0, cnt_q};
                    mem_mode = MODE_BYTE;
                    mem_wd   = {24'b0, wdata_q[{byte_sel, 3'b000} +: 8]};
                end
`endif
                if (state_q == S_CAPTURE) begin
                    state_d = S_RESP;
                    data_d  = mem_rd;
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        data_d = {data_q[23:0], mem_rd[7:0]};
                        if (cnt_q != last_idx) begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = S_ISSUE;
                        end
                    end
`endif
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            cnt_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
`ifdef MISALIGN_SPLIT_EN
            split_q <= split_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
